// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared datapath constants and prefetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int unsigned      XLEN     = 32;
    localparam logic [XLEN-1:0]  RESET_PC = 32'h8000_0000;

    typedef enum logic [0:0] {
        PF_RUN   = 1'b0,
        PF_DRAIN = 1'b1
    } pf_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_fifo.sv
// ============================================================================
// Module      : instr_fifo
// Description : Synchronous FIFO with occupancy count and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    import riscv_pkg::*;

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [WIDTH-1:0]   w_mem_d [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0] r_count_q, w_count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = i_push && !i_clear && (r_count_q != c_CNT_W'(DEPTH));
    assign w_do_pop  = i_pop  && !i_clear && (r_count_q != '0);

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (i_clear) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (w_do_push) begin
                w_mem_d[r_wr_ptr_q] = i_push_data;
                w_wr_ptr_d          = r_wr_ptr_q + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   w_count_d = r_count_q + c_CNT_W'(1);
                2'b01:   w_count_d = r_count_q - c_CNT_W'(1);
                default: w_count_d = r_count_q;
            endcase
        end
    end

    // Storage is zeroed on reset so the head reads 0 straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem_q[i] <= '0;
            end
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_mem_q    <= w_mem_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    assign o_head  = r_mem_q[r_rd_ptr_q];
    assign o_count = r_count_q;

endmodule

`default_nettype wire

// File: rtl/instr_prefetch.sv
// ============================================================================
// Module      : instr_prefetch
// Description : Sequential instruction prefetcher with in-order response FIFO
//               and branch redirect that drains stale in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_prefetch #(
    parameter int unsigned      XLEN     = riscv_pkg::XLEN,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);
    import riscv_pkg::*;

    localparam int unsigned     c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] c_STEP  = XLEN'(4);

    logic [XLEN-1:0]    r_fetch_pc_q,  w_fetch_pc_d;
    logic [XLEN-1:0]    r_held_addr_q, w_held_addr_d;
    logic               r_pend_q,      w_pend_d;
    logic               r_pend_drop_q, w_pend_drop_d;
    logic [c_CNT_W-1:0] r_drop_q,      w_drop_d;
    pf_state_e          r_state_q,     w_state_d;

    logic [c_CNT_W-1:0] w_fifo_cnt;
    logic [c_CNT_W-1:0] w_inflight;
    logic [c_CNT_W-1:0] w_inflight_nx;
    logic [c_CNT_W:0]   w_occupancy;
    logic               w_credit;
    logic               w_req_fire;
    logic               w_rsp_drop;
    logic               w_push;
    logic               w_pop;
    logic [XLEN-1:0]    w_pcq_head;
    logic [XLEN-1:0]    w_redirect_pc;
    logic [2*XLEN-1:0]  w_head;

    assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

    assign w_occupancy = {1'b0, w_fifo_cnt} + {1'b0, w_inflight};
    assign w_credit    = w_occupancy < (c_CNT_W + 1)'(DEPTH);

    assign imem_req_valid_o = !rst_i && (w_credit || r_pend_q);
    assign imem_req_addr_o  = r_pend_q ? r_held_addr_q : r_fetch_pc_q;
    assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;

    assign w_rsp_drop = imem_rsp_valid_i && (r_drop_q != '0);
    assign w_push     = imem_rsp_valid_i && !w_rsp_drop && !redirect_valid_i;

    assign instr_valid_o = (w_fifo_cnt != '0) && !redirect_valid_i;
    assign w_pop         = instr_valid_o && instr_ready_i;

    assign w_inflight_nx = w_inflight + c_CNT_W'(w_req_fire) - c_CNT_W'(imem_rsp_valid_i);

    // fetch_pc advances when a fresh address is first presented; a held
    // request then replays held_addr, leaving fetch_pc free for a redirect.
    always_comb begin
        w_fetch_pc_d  = r_fetch_pc_q;
        w_held_addr_d = r_held_addr_q;
        w_pend_d      = r_pend_q;
        w_pend_drop_d = r_pend_drop_q;
        w_drop_d      = r_drop_q;

        if (imem_req_valid_o && !r_pend_q) begin
            w_fetch_pc_d  = r_fetch_pc_q + c_STEP;
            w_held_addr_d = r_fetch_pc_q;
        end

        if (w_req_fire) begin
            w_pend_d      = 1'b0;
            w_pend_drop_d = 1'b0;
        end else if (imem_req_valid_o) begin
            w_pend_d = 1'b1;
        end

        if (w_rsp_drop) begin
            w_drop_d = w_drop_d - c_CNT_W'(1);
        end
        if (w_req_fire && r_pend_q && r_pend_drop_q) begin
            w_drop_d = w_drop_d + c_CNT_W'(1);
        end

        if (redirect_valid_i) begin
            w_fetch_pc_d = w_redirect_pc;
            w_drop_d     = w_inflight_nx;
            if (imem_req_valid_o && !imem_req_ready_i) begin
                w_pend_drop_d = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            PF_RUN:   if (w_drop_d != '0) w_state_d = PF_DRAIN;
            PF_DRAIN: if (w_drop_d == '0) w_state_d = PF_RUN;
            default:  w_state_d = PF_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc_q  <= RESET_PC;
            r_held_addr_q <= RESET_PC;
            r_pend_q      <= 1'b0;
            r_pend_drop_q <= 1'b0;
            r_drop_q      <= '0;
            r_state_q     <= PF_RUN;
        end else begin
            r_fetch_pc_q  <= w_fetch_pc_d;
            r_held_addr_q <= w_held_addr_d;
            r_pend_q      <= w_pend_d;
            r_pend_drop_q <= w_pend_drop_d;
            r_drop_q      <= w_drop_d;
            r_state_q     <= w_state_d;
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_data_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_clear     (redirect_valid_i),
        .i_push      (w_push),
        .i_push_data ({w_pcq_head, imem_rsp_data_i}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_cnt)
    );

    // Outstanding-request PCs; its occupancy is the in-flight count.
    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_pc_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_clear     (1'b0),
        .i_push      (w_req_fire),
        .i_push_data (imem_req_addr_o),
        .i_pop       (imem_rsp_valid_i),
        .o_head      (w_pcq_head),
        .o_count     (w_inflight)
    );

    assign instr_o = w_head[XLEN-1:0];
    assign pc_o    = w_head[2*XLEN-1:XLEN];

endmodule

`default_nettype wire
